mtm_alu_frame_rx: RTL and testbench
===================================

Name: mtm_alu_frame_rx

Overview:
Parametrised serial frame receiver and checker for the ALU input link. It deserialises 11-bit frames from `sin`, collects 2·DATA_W/8 data bytes (operand B, then operand A, MSB byte first), then a CMD frame. It checks frame count, CRC4 and opcode, and presents one decoded packet or error record on a valid/ready output. It replaces fixed 32-bit receive logic: operand width is a parameter, and it adds backpressure and overrun reporting.

Parameters:
DATA_W, 32, operand width in bits. Legal values are multiples of 8 from 8 to 64. Bytes per packet NB = 2·DATA_W/8.
CRC_EN, 1, set to 0 to skip the CRC check (err_crc is never set).

Ports:
clk  in  1  system clock; `sin` is sampled on the rising edge, one bit per cycle
rst_n  in  1  asynchronous, active-low reset
sin  in  1  serial input, idles high
out_valid  out  1  packet/error record available
out_ready  in  1  consumer accepts the record when out_valid && out_ready
out_a  out  DATA_W  operand A
out_b  out  DATA_W  operand B
out_op  out  3  opcode from the CMD frame
out_err  out  3  {err_data, err_crc, err_op}; zero means a valid packet
ovr  out  1  one-cycle pulse: a completed record was dropped

Behaviour:
- Frame format: start(0), type (0 = DATA, 1 = CMD), d7..d0, stop(1). This is 11 bits, MSB first.
- Bit FSM:
  - IDLE: leave when `sin` is sampled 0.
  - TYPE: capture the type bit.
  - DATA: 8 samples.
  - STOP: on the stop sample, process the frame and return to IDLE. A new start bit may be sampled on the next cycle.
- Packet state: byte counter cnt (0..NB), B/A shift register of 2·DATA_W bits, serial CRC register crc[3:0].
- DATA frame with cnt < NB:
  - shift the byte in and increment cnt;
  - shift each data bit into the CRC as it is sampled.
- DATA frame with cnt == NB (too many frames):
  - emit a record with err = 100;
  - clear cnt and crc;
  - discard this frame.
- CMD frame:
  - feed 1'b1 into the CRC during d7 (the received d7 is ignored);
  - feed d6..d4 into the CRC as the opcode;
  - capture d3..d0 as the received CRC.
- CMD frame evaluation at the stop sample, first match wins:
  - cnt != NB → err = 100;
  - CRC mismatch → err = 010;
  - op not in {000, 001, 100, 101} → err = 001;
  - otherwise err = 000.
  - In all cases: emit a record, then clear cnt and crc.
- CRC4 definition: polynomial x^4+x+1, initial value 0, MSB first, no reflection. Per bit b: fb = crc[3]^b; crc <= {crc[2:0],0} ^ (fb ? 4'b0011 : 0). The CRC covers {B, A, 1'b1, OP}. For DATA_W=32 this equals the 68-bit reference CRC.
- Framing error (stop sampled 0):
  - emit a record with err = 100;
  - clear cnt and crc;
  - return to IDLE.
- Record emission and latency:
  - out_* registers load on the clock edge after the stop sample, and out_valid rises that same edge (1-cycle latency).
  - For error records, out_a/out_b/out_op hold whatever was captured. The consumer ignores them when out_err != 0.
- Handshake:
  - out_valid stays high and out_* stay stable until out_valid && out_ready.
  - If a new record completes while out_valid && !out_ready, the new record is dropped, ovr pulses for 1 cycle, and the held record is unchanged.
  - If a new record completes in the same cycle as a handshake, the new record loads and out_valid stays high.
- Reset values: out_valid=0, ovr=0, out_a=0, out_b=0, out_op=0, out_err=0. FSM=IDLE, cnt=0, crc=0.
- Reset mid-frame or mid-packet aborts all partial state immediately. No record is emitted.

Test Plan:
1. DATA_W=32; B=0x22222222, A=0x11111111, OP=100, correct CRC; out_ready=1 → out_valid for 1 cycle with out_b=0x22222222, out_a=0x11111111, out_op=100, out_err=000, 1 cycle after the CMD stop bit.
2. Same operands, CRC field = correct CRC ^ 4'b0001 → out_err=010. Then OP=010 with correct CRC → out_err=001.
3. Nine DATA frames with no CMD → out_err=100 after the 9th frame. Then 7 DATA frames + CMD → out_err=100. Then a clean packet from scenario 1 → out_err=000.
4. Stop bit of the 3rd DATA frame forced to 0 → out_err=100 on that frame. The following clean packet decodes correctly.
5. Backpressure: out_ready=0; send packet 1 then packet 2. out_valid is held with packet 1 data and ovr pulses once at packet 2 completion. Raising out_ready consumes packet 1 and out_valid falls.
6. DATA_W=16 instance: 4 DATA frames (B=0xFFFF, A=0x0000) + CMD OP=101 with correct CRC → out_b=0xFFFF, out_a=0x0000, out_err=000. Asserting rst_n low during the 2nd frame of a later packet forces all outputs to 0 and no record is emitted.

Source files
------------

// File: rtl/mtm_alu_frame_rx.sv
// Serial frame receiver for the ALU input link: deserialises DATA/CMD frames,
// checks byte count, CRC4 and opcode, and hands out one record via valid/ready.
module mtm_alu_frame_rx #(
  parameter int DATA_W = 32,
  parameter bit CRC_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [2:0]        out_op,
  output logic [2:0]        out_err,
  output logic              ovr
);
  localparam int NB = 2 * DATA_W / 8;
  localparam int CW = $clog2(NB + 1);
  localparam int SW = 2 * DATA_W;

  typedef enum logic [1:0] {S_IDLE, S_TYPE, S_DATA, S_STOP} state_t;
  state_t r_state, w_next;

  logic [2:0]    r_bit;
  logic          r_type;
  logic [7:0]    r_byte;
  logic [CW-1:0] r_cnt;
  logic [SW-1:0] r_sr;
  logic [3:0]    r_crc;
  logic          r_pend;
  logic [2:0]    r_perr;
  logic [2:0]    r_pop;
  logic          w_feed;
  logic          w_fbit;
  logic [3:0]    w_crc_nxt;
  logic [2:0]    w_cmd_err;
  logic          w_full;

  assign w_full = (r_cnt == CW'(NB));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (!sin) w_next = S_TYPE;
      S_TYPE: w_next = S_DATA;
      S_DATA: if (r_bit == 3'd7) w_next = S_STOP;
      S_STOP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // CMD frames feed a constant 1 in place of d7, then the 3 opcode bits.
  always_comb begin
    w_feed = 1'b0;
    w_fbit = sin;
    if (!r_type) begin
      w_feed = 1'b1;
    end else if (r_bit == 3'd0) begin
      w_feed = 1'b1;
      w_fbit = 1'b1;
    end else if (r_bit <= 3'd3) begin
      w_feed = 1'b1;
    end
  end

  assign w_crc_nxt = {r_crc[2:0], 1'b0} ^ ((r_crc[3] ^ w_fbit) ? 4'b0011 : 4'b0000);

  always_comb begin
    w_cmd_err = 3'b000;
    if (!w_full)                              w_cmd_err = 3'b100;
    else if (CRC_EN && (r_crc != r_byte[3:0])) w_cmd_err = 3'b010;
    else if (r_byte[5])                       w_cmd_err = 3'b001;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit  <= '0;
      r_type <= 1'b0;
      r_byte <= '0;
      r_cnt  <= '0;
      r_sr   <= '0;
      r_crc  <= '0;
      r_pend <= 1'b0;
      r_perr <= '0;
      r_pop  <= '0;
    end else begin
      r_pend <= 1'b0;
      case (r_state)
        S_TYPE: begin
          r_type <= sin;
          r_bit  <= '0;
        end
        S_DATA: begin
          r_bit  <= r_bit + 3'd1;
          r_byte <= {r_byte[6:0], sin};
          if (w_feed) r_crc <= w_crc_nxt;
        end
        S_STOP: begin
          if (!sin) begin
            r_pend <= 1'b1;
            r_perr <= 3'b100;
            r_cnt  <= '0;
            r_crc  <= '0;
          end else if (!r_type) begin
            if (w_full) begin
              r_pend <= 1'b1;
              r_perr <= 3'b100;
              r_cnt  <= '0;
              r_crc  <= '0;
            end else begin
              r_sr  <= {r_sr[SW-9:0], r_byte};
              r_cnt <= r_cnt + CW'(1);
            end
          end else begin
            r_pend <= 1'b1;
            r_perr <= w_cmd_err;
            r_pop  <= r_byte[6:4];
            r_cnt  <= '0;
            r_crc  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Records are staged one cycle in r_pend so the output stage sees a settled shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_op    <= '0;
      out_err   <= '0;
      ovr       <= 1'b0;
    end else begin
      ovr <= 1'b0;
      if (r_pend) begin
        if (!out_valid || out_ready) begin
          out_valid <= 1'b1;
          out_a     <= r_sr[DATA_W-1:0];
          out_b     <= r_sr[SW-1:DATA_W];
          out_op    <= r_pop;
          out_err   <= r_perr;
        end else begin
          ovr <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mtm_alu_frame_rx.sv
// Directed + random bench for mtm_alu_frame_rx (32-bit and 16-bit instances)
// against a byte-queue reference model with a polynomial-division CRC.
module tb_mtm_alu_frame_rx;
  logic        clk = 1'b0;
  logic        rst32_n, rst16_n, sin32, sin16, ready;
  logic        v32, v16, ovr32, ovr16;
  logic [31:0] a32, b32;
  logic [15:0] a16, b16;
  logic [2:0]  op32, op16, err32, err16;

  logic        obs_valid, obs_ovr;
  logic [63:0] obs_a, obs_b;
  logic [2:0]  obs_op, obs_err;

  int   total = 0;
  int   bad = 0;
  int   ovr_cnt = 0;
  bit   sel = 1'b0;
  bit   autochk = 1'b1;
  logic [7:0] q[$];
  bit          m_has;
  logic [2:0]  m_err, m_op;
  logic [63:0] m_a, m_b;

  always #5 clk = ~clk;

  mtm_alu_frame_rx #(.DATA_W(32), .CRC_EN(1'b1)) u32 (
    .clk(clk), .rst_n(rst32_n), .sin(sin32), .out_valid(v32), .out_ready(ready),
    .out_a(a32), .out_b(b32), .out_op(op32), .out_err(err32), .ovr(ovr32));

  mtm_alu_frame_rx #(.DATA_W(16), .CRC_EN(1'b1)) u16 (
    .clk(clk), .rst_n(rst16_n), .sin(sin16), .out_valid(v16), .out_ready(ready),
    .out_a(a16), .out_b(b16), .out_op(op16), .out_err(err16), .ovr(ovr16));

  always_comb begin
    obs_valid = sel ? v16 : v32;
    obs_ovr   = sel ? ovr16 : ovr32;
    obs_a     = sel ? 64'(a16) : 64'(a32);
    obs_b     = sel ? 64'(b16) : 64'(b32);
    obs_op    = sel ? op16 : op32;
    obs_err   = sel ? err16 : err32;
  end

  always @(posedge clk) if (obs_ovr === 1'b1) ovr_cnt <= ovr_cnt + 1;

  function automatic int cur_nb();
    return sel ? 4 : 8;
  endfunction

  function automatic int cur_dw();
    return sel ? 16 : 32;
  endfunction

  // Remainder of M(x)*x^4 mod (x^4+x+1), nbits message bits right-aligned in msg.
  function automatic logic [3:0] crc_ref(input logic [131:0] msg, input int nbits);
    logic [135:0] m;
    m = {msg, 4'b0000};
    for (int i = nbits + 3; i >= 4; i--)
      if (m[i]) m = m ^ (136'(5'b10011) << (i - 4));
    return m[3:0];
  endfunction

  function automatic logic [3:0] pkt_crc(input logic [63:0] b, input logic [63:0] a,
                                         input logic [2:0] op, input int dw);
    logic [131:0] msg;
    msg = (132'(b) << (dw + 4)) | (132'(a) << 4) | 132'({1'b1, op});
    return crc_ref(msg, 2 * dw + 4);
  endfunction

  function automatic logic [7:0] pkt_byte(input logic [63:0] b, input logic [63:0] a,
                                          input int i, input int nb);
    int half;
    half = nb / 2;
    if (i < half) return 8'(b >> (8 * (half - 1 - i)));
    return 8'(a >> (8 * (nb - 1 - i)));
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic drive(input logic b);
    if (sel) sin16 = b;
    else     sin32 = b;
  endtask

  task automatic model_frame(input bit typ, input logic [7:0] d, input bit stop_ok);
    int nb;
    logic [63:0] a, b;
    logic [2:0] op;
    nb = cur_nb();
    m_has = 1'b0;
    if (!stop_ok) begin
      m_has = 1'b1; m_err = 3'b100; q.delete();
    end else if (!typ) begin
      if (q.size() == nb) begin
        m_has = 1'b1; m_err = 3'b100; q.delete();
      end else begin
        q.push_back(d);
      end
    end else begin
      m_has = 1'b1;
      op = d[6:4];
      if (q.size() != nb) begin
        m_err = 3'b100;
      end else begin
        b = '0; a = '0;
        for (int i = 0; i < nb / 2; i++)  b = (b << 8) | 64'(q[i]);
        for (int i = nb / 2; i < nb; i++) a = (a << 8) | 64'(q[i]);
        m_a = a; m_b = b; m_op = op;
        if (d[3:0] != pkt_crc(b, a, op, cur_dw())) m_err = 3'b010;
        else if (op inside {3'b000, 3'b001, 3'b100, 3'b101}) m_err = 3'b000;
        else m_err = 3'b001;
      end
      q.delete();
    end
  endtask

  task automatic send_frame(input bit typ, input logic [7:0] d, input bit stop_ok);
    logic [10:0] f;
    f = {1'b0, typ, d, stop_ok};
    for (int i = 10; i >= 0; i--) begin
      @(negedge clk);
      drive(f[i]);
    end
    @(negedge clk);
    drive(1'b1);
    model_frame(typ, d, stop_ok);
    if (autochk) begin
      @(negedge clk);
      if (m_has) begin
        chk("rec_valid", 64'(obs_valid), 64'd1);
        chk("rec_err", 64'(obs_err), 64'(m_err));
        if (m_err == 3'b000) begin
          chk("rec_a", obs_a, m_a);
          chk("rec_b", obs_b, m_b);
          chk("rec_op", 64'(obs_op), 64'(m_op));
        end
        @(negedge clk);
        chk("valid_fall", 64'(obs_valid), 64'd0);
      end else begin
        chk("no_rec", 64'(obs_valid), 64'd0);
      end
    end
  endtask

  task automatic send_pkt(input logic [63:0] b, input logic [63:0] a, input logic [2:0] op,
                          input logic [3:0] cx, input int nd, input bit with_cmd);
    int nb;
    logic [3:0] c;
    nb = cur_nb();
    for (int i = 0; i < nd; i++)
      send_frame(1'b0, (i < nb) ? pkt_byte(b, a, i, nb) : 8'($urandom), 1'b1);
    if (with_cmd) begin
      c = pkt_crc(b, a, op, cur_dw()) ^ cx;
      send_frame(1'b1, {1'($urandom), op, c}, 1'b1);
    end
  endtask

  initial begin
    int base;
    int nd, r;
    logic [63:0] rb, ra, mk;
    logic [3:0] cx;
    rst32_n = 1'b0; rst16_n = 1'b0; sin32 = 1'b1; sin16 = 1'b1; ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(v32), 64'd0);
    chk("rst_a", 64'(a32), 64'd0);
    chk("rst_b", 64'(b32), 64'd0);
    chk("rst_err", 64'(err32), 64'd0);
    chk("rst_ovr", 64'(ovr32), 64'd0);
    rst32_n = 1'b1; rst16_n = 1'b1;
    repeat (2) @(negedge clk);

    // Clean packet, CRC error, illegal opcode
    send_pkt(64'h22222222, 64'h11111111, 3'b100, 4'h0, 8, 1'b1);
    send_pkt(64'h22222222, 64'h11111111, 3'b100, 4'h1, 8, 1'b1);
    send_pkt(64'h22222222, 64'h11111111, 3'b010, 4'h0, 8, 1'b1);
    // Too many frames, too few frames, then recovery
    send_pkt(64'h22222222, 64'h11111111, 3'b000, 4'h0, 9, 1'b0);
    send_pkt(64'h22222222, 64'h11111111, 3'b000, 4'h0, 7, 1'b1);
    send_pkt(64'h22222222, 64'h11111111, 3'b100, 4'h0, 8, 1'b1);
    // Framing error on the third data frame, then recovery
    send_frame(1'b0, 8'h22, 1'b1);
    send_frame(1'b0, 8'h22, 1'b1);
    send_frame(1'b0, 8'h22, 1'b0);
    send_pkt(64'hDEADBEEF, 64'h01234567, 3'b001, 4'h0, 8, 1'b1);

    // Backpressure: second record is dropped with a single ovr pulse
    autochk = 1'b0; ready = 1'b0;
    send_pkt(64'h22222222, 64'h11111111, 3'b100, 4'h0, 8, 1'b1);
    @(negedge clk);
    chk("bp_valid1", 64'(obs_valid), 64'd1);
    chk("bp_b1", obs_b, 64'h22222222);
    base = ovr_cnt;
    send_pkt(64'h33333333, 64'h44444444, 3'b000, 4'h0, 8, 1'b1);
    @(negedge clk);
    chk("bp_ovr_hi", 64'(obs_ovr), 64'd1);
    chk("bp_hold_b", obs_b, 64'h22222222);
    chk("bp_hold_a", obs_a, 64'h11111111);
    chk("bp_hold_op", 64'(obs_op), 64'd4);
    @(negedge clk);
    chk("bp_ovr_lo", 64'(obs_ovr), 64'd0);
    chk("bp_ovr_cnt", 64'(ovr_cnt - base), 64'd1);
    ready = 1'b1;
    @(negedge clk);
    chk("bp_consumed", 64'(obs_valid), 64'd0);
    autochk = 1'b1;

    // 16-bit instance: clean packet, then reset during a later packet
    sel = 1'b1;
    send_pkt(64'hFFFF, 64'h0000, 3'b101, 4'h0, 4, 1'b1);
    autochk = 1'b0; ready = 1'b0;
    send_pkt(64'hA5C3, 64'h0F0F, 3'b001, 4'h0, 4, 1'b1);
    @(negedge clk);
    chk("r16_held", 64'(obs_valid), 64'd1);
    send_frame(1'b0, 8'h12, 1'b1);
    @(negedge clk); drive(1'b0);
    @(negedge clk); drive(1'b0);
    @(negedge clk); drive(1'b1);
    @(negedge clk); drive(1'b0);
    @(negedge clk);
    rst16_n = 1'b0; drive(1'b1); q.delete();
    #1;
    chk("r16_valid", 64'(obs_valid), 64'd0);
    chk("r16_a", obs_a, 64'd0);
    chk("r16_b", obs_b, 64'd0);
    chk("r16_op", 64'(obs_op), 64'd0);
    chk("r16_err", 64'(obs_err), 64'd0);
    @(negedge clk);
    rst16_n = 1'b1; ready = 1'b1;
    repeat (20) @(negedge clk);
    chk("r16_no_rec", 64'(obs_valid), 64'd0);
    autochk = 1'b1;
    send_pkt(64'h1234, 64'hABCD, 3'b000, 4'h0, 4, 1'b1);

    // Random packets on both widths
    for (int it = 0; it < 24; it++) begin
      sel = it[0];
      mk = (64'd1 << cur_dw()) - 64'd1;
      rb = {$urandom, $urandom} & mk;
      ra = {$urandom, $urandom} & mk;
      cx = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      r = $urandom_range(0, 9);
      nd = (r == 0) ? cur_nb() - 1 : (r == 1) ? cur_nb() + 1 : cur_nb();
      send_pkt(rb, ra, 3'($urandom_range(0, 7)), cx, nd, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
